// File: rtl/usb_tx_frame_packer.sv
// usb_tx_frame_packer
//
// Packs an 8-bit pixel stream into framed, block-aligned byte bursts for the
// USB tx FIFO. Each frame becomes a 4-byte header (A5 5A id_lo id_hi), the
// FRAME_PIXELS pixel bytes, and zero padding up to a multiple of BLOCK_BYTES.
// A running count of bytes sitting in the FIFO drives the pipe-out
// block-ready indication.
//
// Ports:
//   clk, rst        sole clock; asynchronous active-high reset
//   enable          allows a new frame to start (looked at only in IDLE)
//   pix_data/valid/sof/ready   pixel stream handshake
//   fifo_din, fifo_wr_en, fifo_full   tx FIFO write side
//   blk_done        one block of BLOCK_BYTES was read out of the FIFO
//   tx_block_ready  at least one whole block is buffered
//   frame_id        id of the frame being packed or next to be packed
//   frame_done      one-cycle pulse after the last byte of a frame
//   sof_err         sticky: SOF seen on a beat other than the first
//   underflow_err   sticky: blk_done with less than a block outstanding
//
// state  | meaning
// IDLE   | waiting for SOF; non-SOF pixels are consumed and dropped
// HEADER | writing the 4 header bytes
// PIXELS | forwarding FRAME_PIXELS pixel bytes
// PAD    | writing 0x00 until the frame length is block aligned

module usb_tx_frame_packer #(
    parameter int FRAME_PIXELS = 102240,
    parameter int BLOCK_BYTES  = 1024,
    parameter int CNT_W        = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [7:0]  fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    input  logic        blk_done,
    output logic        tx_block_ready,
    output logic [15:0] frame_id,
    output logic        frame_done,
    output logic        sof_err,
    output logic        underflow_err
);

    localparam int OFS_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int PIX_W = $clog2(FRAME_PIXELS + 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [OFS_W-1:0] OFS_LAST  = OFS_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] BLK_CNT   = CNT_W'(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PIXELS = 2'd2,
        PAD    = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         hdr_idx_q;
    logic [PIX_W-1:0]   pix_cnt_q;
    // Frame byte count modulo BLOCK_BYTES; BLOCK_BYTES is a power of two
    // so the natural wrap of this counter does the modulo.
    logic [OFS_W-1:0]   blk_ofs_q;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   out_cnt_inc;
    logic [15:0]        frame_id_q;
    logic               frame_done_q;
    logic               sof_err_q;
    logic               underflow_err_q;
    logic               wr;
    logic               done_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr        = 1'b0;
        fifo_din  = 8'h00;
        pix_ready = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            IDLE: begin
                pix_ready = enable && !pix_sof;
                // The SOF beat stays on the bus and becomes pixel 0.
                if (enable && pix_valid && pix_sof) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                wr = !fifo_full;
                case (hdr_idx_q)
                    2'd0:    fifo_din = 8'hA5;
                    2'd1:    fifo_din = 8'h5A;
                    2'd2:    fifo_din = frame_id_q[7:0];
                    default: fifo_din = frame_id_q[15:8];
                endcase
                if (wr && hdr_idx_q == 2'd3) begin
                    state_d = PIXELS;
                end
            end
            PIXELS: begin
                pix_ready = !fifo_full;
                fifo_din  = pix_data;
                wr        = pix_valid && !fifo_full;
                if (wr && pix_cnt_q == LAST_PIX) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (blk_ofs_q == '0) begin
                    // Already aligned on entry: nothing to pad.
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wr = !fifo_full;
                    if (wr && blk_ofs_q == OFS_LAST) begin
                        done_set = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_wr_en  = wr;
    assign out_cnt_inc = out_cnt + {{(CNT_W-1){1'b0}}, wr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_idx_q       <= 2'd0;
            pix_cnt_q       <= '0;
            blk_ofs_q       <= '0;
            frame_id_q      <= 16'h0000;
            frame_done_q    <= 1'b0;
            sof_err_q       <= 1'b0;
            underflow_err_q <= 1'b0;
            out_cnt         <= '0;
        end else begin
            if (state_q == IDLE) begin
                hdr_idx_q <= 2'd0;
                pix_cnt_q <= '0;
                blk_ofs_q <= '0;
            end else begin
                if (state_q == HEADER && wr) begin
                    hdr_idx_q <= hdr_idx_q + 2'd1;
                end
                if (state_q == PIXELS && wr) begin
                    pix_cnt_q <= pix_cnt_q + 1'b1;
                end
                if (wr) begin
                    blk_ofs_q <= blk_ofs_q + 1'b1;
                end
            end

            // SOF is tolerated as data; only flagged.
            if (state_q == PIXELS && wr && pix_sof && pix_cnt_q != '0) begin
                sof_err_q <= 1'b1;
            end

            // Assigned every cycle so the id is always the registered copy.
            frame_id_q   <= done_set ? frame_id_q + 16'd1 : frame_id_q;
            frame_done_q <= done_set;

            // A same-cycle write counts before the block is taken away.
            if (blk_done) begin
                if (out_cnt_inc >= BLK_CNT) begin
                    out_cnt <= out_cnt_inc - BLK_CNT;
                end else begin
                    out_cnt         <= out_cnt_inc;
                    underflow_err_q <= 1'b1;
                end
            end else begin
                out_cnt <= out_cnt_inc;
            end
        end
    end

    assign tx_block_ready = (out_cnt >= BLK_CNT);
    assign frame_id       = frame_id_q;
    assign frame_done     = frame_done_q;
    assign sof_err        = sof_err_q;
    assign underflow_err  = underflow_err_q;

endmodule

// File: tb/tb_usb_tx_frame_packer.sv
module tb_usb_tx_frame_packer;

    localparam int NPIX = 10;
    localparam int BLK  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        blk_done;
    logic        tx_block_ready;
    logic [15:0] frame_id;
    logic        frame_done;
    logic        sof_err;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int done_cnt = 0;
    int model_cnt = 0;
    logic [7:0] exp_q[$];

    usb_tx_frame_packer #(.FRAME_PIXELS(NPIX), .BLOCK_BYTES(BLK), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .blk_done(blk_done), .tx_block_ready(tx_block_ready), .frame_id(frame_id),
        .frame_done(frame_done), .sof_err(sof_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: inputs only change at posedge+1, so at negedge the write
    // strobe and blk_done are exactly what the next posedge will see.
    always @(negedge clk) begin
        if (rst) begin
            model_cnt = 0;
        end else begin
            if (fifo_wr_en) begin
                wr_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%02h required=no_write", fifo_din);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (fifo_din !== e) begin
                        errors++;
                        $display("FAIL fifo_byte actual=%02h required=%02h", fifo_din, e);
                    end
                end
            end
            if (fifo_full) chk("wr_while_full", int'(fifo_wr_en), 0);
            chk("tx_block_ready", int'(tx_block_ready), int'(model_cnt >= BLK));
            if (frame_done) begin
                done_cnt++;
                chk("bytes_left_at_frame_done", exp_q.size(), 0);
            end
            model_cnt = model_cnt + int'(fifo_wr_en);
            if (blk_done && model_cnt >= BLK) model_cnt = model_cnt - BLK;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input logic [7:0] d, input logic s);
        bit acc = 0;
        int n = 0;
        pix_data = d;
        pix_sof = s;
        pix_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = pix_ready;
            cyc();
            n++;
        end
        if (!acc) chk("pixel_accept_timeout", 0, 1);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic pulse_blk();
        blk_done = 1'b1;
        cyc();
        blk_done = 1'b0;
    endtask

    // Sends one frame; sof_at marks an extra SOF, npix < NPIX aborts early,
    // coincide raises blk_done on the first header write.
    task automatic send_frame(input logic [15:0] id, input int sof_at, input int npix,
                              input bit coincide);
        int d0 = done_cnt;
        int n = 0;
        int tot = 4 + NPIX;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(id[7:0]);
        exp_q.push_back(id[15:8]);
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(i + 1));
        for (int i = 0; i < (BLK - tot % BLK) % BLK; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < npix; i++) begin
            if (i == 0 && coincide) begin
                pix_data = 8'h01;
                pix_sof = 1'b1;
                pix_valid = 1'b1;
                cyc();
                pulse_blk();
                chk("out_cnt_coincident", int'(dut.out_cnt), 1);
            end
            push_pixel(8'(i + 1), (i == 0) || (i == sof_at));
        end
        if (npix == NPIX) begin
            while (done_cnt == d0 && n < 200) begin
                cyc();
                n++;
            end
            chk("frame_done_count", done_cnt - d0, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        pix_data = 8'h00;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        fifo_full = 1'b0;
        blk_done = 1'b0;
        cyc();
        cyc();
        chk("rst_fifo_wr_en", int'(fifo_wr_en), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_tx_block_ready", int'(tx_block_ready), 0);
        chk("rst_frame_id", int'(frame_id), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_errs", int'({sof_err, underflow_err}), 0);
        rst = 1'b0;
        enable = 1'b1;
        cyc();

        // Non-SOF pixels in IDLE are consumed without writes
        for (int i = 0; i < 3; i++) push_pixel(8'hE0 + 8'(i), 1'b0);
        chk("idle_drop_writes", wr_total, 0);

        // Basic frame
        send_frame(16'h0000, -1, NPIX, 1'b0);
        chk("f1_frame_id", int'(frame_id), 1);
        chk("f1_out_cnt", int'(dut.out_cnt), 16);
        chk("f1_sof_err", int'(sof_err), 0);

        // Block accounting
        pulse_blk();
        chk("blk1_out_cnt", int'(dut.out_cnt), 8);
        chk("blk1_ready", int'(tx_block_ready), 1);
        pulse_blk();
        chk("blk2_out_cnt", int'(dut.out_cnt), 0);
        chk("blk2_ready", int'(tx_block_ready), 0);
        chk("blk2_underflow", int'(underflow_err), 0);
        pulse_blk();
        chk("blk3_underflow", int'(underflow_err), 1);
        chk("blk3_out_cnt", int'(dut.out_cnt), 0);

        // Back-pressure in HEADER then in PIXELS
        fork
            send_frame(16'h0001, -1, NPIX, 1'b0);
            begin
                int base = wr_total;
                int n = 0;
                while (wr_total < base + 2 && n < 100) begin cyc(); n++; end
                fifo_full = 1'b1;
                repeat (5) cyc();
                fifo_full = 1'b0;
                n = 0;
                while (wr_total < base + 8 && n < 100) begin cyc(); n++; end
                fifo_full = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("pix_ready_while_full", int'(pix_ready), 0);
                    cyc();
                end
                fifo_full = 1'b0;
                chk("bp_progress", int'(n < 100), 1);
            end
        join
        chk("f2_frame_id", int'(frame_id), 2);
        chk("f2_out_cnt", int'(dut.out_cnt), 16);

        // blk_done coincident with a write at out_cnt=8
        pulse_blk();
        chk("pre_coincide_out_cnt", int'(dut.out_cnt), 8);
        send_frame(16'h0002, -1, NPIX, 1'b1);
        chk("f3_out_cnt", int'(dut.out_cnt), 16);

        // Mid-frame SOF on pixel 5
        send_frame(16'h0003, 4, NPIX, 1'b0);
        chk("f4_sof_err", int'(sof_err), 1);
        chk("f4_frame_id", int'(frame_id), 4);

        // Reset after pixel 4
        send_frame(16'h0004, -1, 4, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_state", int'(2'(dut.state_q)), 0);
        chk("rst_mid_out_cnt", int'(dut.out_cnt), 0);
        chk("rst_mid_frame_id", int'(frame_id), 0);
        chk("rst_mid_errs", int'({sof_err, underflow_err}), 0);
        cyc();
        rst = 1'b0;
        cyc();

        // frame_id wrap
        force dut.frame_id_q = 16'hFFFF;
        cyc();
        cyc();
        release dut.frame_id_q;
        cyc();
        chk("preset_frame_id", int'(frame_id), 16'hFFFF);
        send_frame(16'hFFFF, -1, NPIX, 1'b0);
        chk("wrap_frame_id", int'(frame_id), 0);

        repeat (3) cyc();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_frame_packer.md
Name: usb_tx_frame_packer

Overview:
- Sits directly upstream of the USB driver's PC-bound byte FIFO and its block-throttled pipe-out endpoint.
- Accepts an 8-bit pixel stream from the capture path, which by default carries 426x240 frames.
- Frames each image with a 4-byte header, pads the frame to a whole number of USB blocks, and writes bytes into the tx FIFO under full back-pressure.
- Tracks how many complete blocks are buffered and drives the block-ready indication for the pipe-out endpoint.

Parameters:
- FRAME_PIXELS, 102240, pixel bytes per frame (426*240).
- BLOCK_BYTES, 1024, bytes per pipe-out block transfer; must be a power of two.
- CNT_W, 24, width of the byte counters; must satisfy 2^CNT_W > FIFO depth + BLOCK_BYTES.

Ports:
- clk  input  1  system clock; the sole clock of the block.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  allows a new frame to start; sampled only in IDLE.
- pix_data  input  8  pixel byte.
- pix_valid  input  1  pix_data is valid.
- pix_sof  input  1  qualifies the first pixel of a frame.
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
- fifo_din  output  8  byte to the tx FIFO.
- fifo_wr_en  output  1  tx FIFO write strobe.
- fifo_full  input  1  tx FIFO full.
- blk_done  input  1  one-cycle pulse in the clk domain meaning one block of BLOCK_BYTES has been read out.
- tx_block_ready  output  1  at least one full block is buffered.
- frame_id  output  16  id of the frame currently being packed or next to be packed.
- frame_done  output  1  one-cycle pulse when the last pad byte of a frame is written.
- sof_err  output  1  sticky flag: SOF seen mid-frame.
- underflow_err  output  1  sticky flag: blk_done arrived while fewer than BLOCK_BYTES were outstanding.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All counters = 0, frame_id = 0, both sticky errors = 0, frame_done = 0.
  - Combinational outputs fall to 0 as a consequence: fifo_wr_en = 0, pix_ready = 0, tx_block_ready = 0.
  - Reset mid-frame abandons the partial frame; the FIFO is not flushed by this block.
- fifo_wr_en and fifo_din are combinational from the registered state: wr = write-state && !fifo_full.
  - Zero-cycle latency to the full flag, so the block never writes into a full FIFO.
- States:
  - IDLE:
    - pix_ready = enable && !pix_sof, so non-SOF pixels are consumed and dropped.
    - On enable && pix_valid && pix_sof, go to HEADER. The SOF beat is not consumed.
  - HEADER: writes 4 bytes in order 0xA5, 0x5A, frame_id[7:0], frame_id[15:8].
    - hdr_idx advances only on a write; after byte 3, go to PIXELS.
  - PIXELS:
    - pix_ready = !fifo_full.
    - fifo_din = pix_data; fifo_wr_en = pix_valid && !fifo_full.
    - Counts accepted pixels; after the FRAME_PIXELS-th, go to PAD.
    - If pix_sof is set on any accepted beat other than the first: set sof_err; the byte is still packed as data (no resync).
  - PAD:
    - Writes 0x00 while the frame byte count (4 + pixels + pads) mod BLOCK_BYTES != 0, stalling on full.
    - When aligned: pulse frame_done, increment frame_id (wraps 0xFFFF -> 0), go to IDLE.
    - With default parameters there are 156 pad bytes and the total is 102400 (100 blocks).
    - If the count is already aligned on entry, PAD writes nothing: frame_done the next cycle.
- enable is only checked in IDLE; deasserting it mid-frame lets the current frame complete.
- Outstanding byte counter out_cnt (CNT_W bits):
  - +1 on each fifo_wr_en cycle.
  - -BLOCK_BYTES on blk_done.
  - Both in the same cycle: net +1-BLOCK_BYTES.
  - blk_done with out_cnt < BLOCK_BYTES (after the same-cycle write is counted): ignore the decrement and set underflow_err.
- tx_block_ready = (out_cnt >= BLOCK_BYTES), decoded from the register. It rises the cycle after the write that completes a block.

Test Plan:
- Use FRAME_PIXELS=10, BLOCK_BYTES=8, fifo_full=0, enable=1.
  - Stimulus: SOF plus 10 pixels 0x01..0x0A.
  - Required: FIFO receives A5 5A 00 00 01..0A 00 00 (16 bytes); frame_done pulses once; frame_id becomes 1; tx_block_ready rises the cycle after byte 8.
- Back-pressure: hold fifo_full=1 for 5 cycles in the middle of HEADER, then in PIXELS.
  - Required: no fifo_wr_en while full; pix_ready=0; byte order identical to the first scenario.
- Block accounting: after 16 bytes are written, pulse blk_done twice.
  - Required: out_cnt goes 16 -> 8 -> 0; tx_block_ready drops after the second pulse.
  - A third pulse sets underflow_err and leaves out_cnt=0.
  - blk_done coincident with a write at out_cnt=8 leaves out_cnt=1.
- Idle dropping and mid-frame SOF:
  - Stimulus: 3 non-SOF pixels in IDLE.
  - Required: they are consumed with no writes.
  - Stimulus: SOF on pixel 5 of a frame.
  - Required: sof_err=1; the frame is still 16 bytes.
- Reset and wrap:
  - Stimulus: assert rst after pixel 4.
  - Required: state IDLE, out_cnt=0, frame_id=0 immediately.
  - Stimulus: preset frame_id=0xFFFF and run one frame.
  - Required: header bytes FF FF; frame_id then 0.
